// File: rtl/writeback_stage.sv
// Write-back stage of the multicycle MIPS datapath: captures the retiring result,
// commits it to the 32x32 register file one cycle later and signals fetch.
module writeback_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        stage5,
  input  logic        regWrite,
  input  logic        memToReg,
  input  logic        regDst,
  input  logic        link,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] aluresult,
  input  logic [31:0] memvalue,
  input  logic [31:0] pcplus4,
  input  logic [4:0]  rsaddr,
  input  logic [4:0]  rtaddr,
  output logic [31:0] rsdata,
  output logic [31:0] rtdata,
  output logic        stage1,
  output logic [31:0] retired,
  output logic        overrun
);

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t      state;
  logic [31:0] regs [32];
  logic [4:0]  l_dest;
  logic [31:0] l_data;
  logic        l_we;

  logic [4:0]  dest;
  logic [31:0] wdata;
  logic        we;

  // Destination, data and enable are resolved on the latching edge, so only the
  // resolved values are held rather than every raw control field.
  always_comb begin
    dest  = link ? 5'd31 : (regDst ? rd : rt);
    wdata = link ? pcplus4 : (memToReg ? memvalue : aluresult);
    we    = (regWrite | link) && (dest != 5'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      stage1  <= 1'b0;
      retired <= '0;
      overrun <= 1'b0;
      l_dest  <= '0;
      l_data  <= '0;
      l_we    <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      stage1 <= 1'b0;
      case (state)
        IDLE: begin
          if (stage5) begin
            l_dest <= dest;
            l_data <= wdata;
            l_we   <= we;
            state  <= COMMIT;
          end
        end
        COMMIT: begin
          if (l_we) regs[l_dest] <= l_data;
          retired <= retired + 32'd1;
          stage1  <= 1'b1;
          state   <= IDLE;
          if (stage5) overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // No bypass: a committed value is visible only after the committing edge.
  always_comb begin
    rsdata = regs[rsaddr];
    rtdata = regs[rtaddr];
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stage5, regWrite, memToReg, regDst, link;
  logic [4:0]  rt, rd, rsaddr, rtaddr;
  logic [31:0] aluresult, memvalue, pcplus4;
  logic [31:0] rsdata, rtdata, retired;
  logic        stage1, overrun;

  int errors = 0;
  int checks = 0;

  writeback_stage dut (
    .clock(clock), .reset(reset), .stage5(stage5), .regWrite(regWrite),
    .memToReg(memToReg), .regDst(regDst), .link(link), .rt(rt), .rd(rd),
    .aluresult(aluresult), .memvalue(memvalue), .pcplus4(pcplus4),
    .rsaddr(rsaddr), .rtaddr(rtaddr), .rsdata(rsdata), .rtdata(rtdata),
    .stage1(stage1), .retired(retired), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an instruction at the negedge, let edge N sample it, drop stage5.
  task automatic issue(input logic rw, input logic m2r, input logic dst, input logic lk,
                       input logic [4:0] trt, input logic [4:0] trd,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    @(negedge clock);
    stage5 = 1'b1; regWrite = rw; memToReg = m2r; regDst = dst; link = lk;
    rt = trt; rd = trd; aluresult = alu; memvalue = mem; pcplus4 = pc;
    @(posedge clock); #1;
    stage5 = 1'b0;
  endtask

  task automatic next_edge();
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; stage5 = 1'b0; regWrite = 1'b0; memToReg = 1'b0; regDst = 1'b0;
    link = 1'b0; rt = '0; rd = '0; aluresult = '0; memvalue = '0; pcplus4 = '0;
    rsaddr = '0; rtaddr = '0;
    #12;
    chk("reset_stage1", {31'd0, stage1}, 32'd0);
    chk("reset_retired", retired, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_r0", rsdata, 32'd0);
    @(negedge clock); reset = 1'b0;

    // Reset in the middle of COMMIT abandons the write.
    issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 32'h0000_1234, '0, '0);
    #2 reset = 1'b1;
    #1;
    rsaddr = 5'd5;
    #1;
    chk("midreset_r5", rsdata, 32'd0);
    chk("midreset_retired", retired, 32'd0);
    chk("midreset_stage1", {31'd0, stage1}, 32'd0);
    next_edge();
    chk("midreset_stage1_late", {31'd0, stage1}, 32'd0);
    @(negedge clock); reset = 1'b0;
    next_edge();
    chk("midreset_r5_after", rsdata, 32'd0);

    // ALU result to rd.
    rsaddr = 5'd8;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 5'd8, 32'hDEAD_BEEF, 32'h1111_1111, '0);
    chk("alu_before_commit", rsdata, 32'd0);
    chk("alu_stage1_low", {31'd0, stage1}, 32'd0);
    next_edge();
    chk("alu_r8", rsdata, 32'hDEAD_BEEF);
    chk("alu_stage1_pulse", {31'd0, stage1}, 32'd1);
    chk("alu_retired", retired, 32'd1);
    next_edge();
    chk("alu_stage1_clear", {31'd0, stage1}, 32'd0);

    // Load to rt, then load targeting r0.
    issue(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd8, 32'h7777_7777, 32'h0000_0042, '0);
    next_edge();
    rsaddr = 5'd9; rtaddr = 5'd8; #1;
    chk("load_r9", rsdata, 32'h0000_0042);
    chk("load_r8_kept", rtdata, 32'hDEAD_BEEF);
    chk("load_retired", retired, 32'd2);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd8, '0, 32'h0000_0099, '0);
    next_edge();
    rsaddr = 5'd0; #1;
    chk("load_r0_zero", rsdata, 32'd0);
    chk("load_r0_retired", retired, 32'd3);

    // Link writes pcplus4 to r31 regardless of regWrite/regDst.
    issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 5'd3, 32'h5555_5555, 32'h6666_6666, 32'h0040_0010);
    next_edge();
    rsaddr = 5'd31; rtaddr = 5'd3; #1;
    chk("link_r31", rsdata, 32'h0040_0010);
    chk("link_r3_untouched", rtdata, 32'd0);
    chk("link_retired", retired, 32'd4);

    // Both read ports on the same register, before and after the commit edge.
    rsaddr = 5'd12; rtaddr = 5'd12;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd12, 32'hA5A5_A5A5, '0, '0);
    @(negedge clock);
    chk("read_rs_old", rsdata, 32'd0);
    chk("read_rt_old", rtdata, 32'd0);
    next_edge();
    chk("read_rs_new", rsdata, 32'hA5A5_A5A5);
    chk("read_rt_new", rtdata, 32'hA5A5_A5A5);

    // Back-to-back: stage5 again at N+2 is accepted.
    issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd13, 32'd1, '0, '0);
    next_edge();
    stage5 = 1'b1; rd = 5'd14; aluresult = 32'd2;
    next_edge();
    stage5 = 1'b0;
    next_edge();
    rsaddr = 5'd13; rtaddr = 5'd14; #1;
    chk("b2b_r13", rsdata, 32'd1);
    chk("b2b_r14", rtdata, 32'd2);
    chk("b2b_retired", retired, 32'd7);
    chk("b2b_no_overrun", {31'd0, overrun}, 32'd0);

    // Overrun: stage5 held into COMMIT is dropped; changed inputs are ignored.
    issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd15, 32'd3, '0, '0);
    stage5 = 1'b1; rd = 5'd16; aluresult = 32'd4;
    next_edge();
    stage5 = 1'b0;
    next_edge(); next_edge();
    rsaddr = 5'd15; rtaddr = 5'd16; #1;
    chk("ovr_r15", rsdata, 32'd3);
    chk("ovr_r16_dropped", rtdata, 32'd0);
    chk("ovr_retired", retired, 32'd8);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    next_edge(); next_edge();
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Retired counter wrap.
    @(negedge clock);
    force dut.retired = 32'hFFFF_FFFF;
    #1 release dut.retired;
    #1;
    chk("wrap_preload", retired, 32'hFFFF_FFFF);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 5'd20, 5'd21, 32'hFFFF_0000, '0, '0);
    next_edge();
    chk("wrap_zero", retired, 32'd0);
    chk("wrap_stage1", {31'd0, stage1}, 32'd1);
    rsaddr = 5'd20; #1;
    chk("wrap_no_write", rsdata, 32'd0);

    // Final reset clears everything.
    @(negedge clock); reset = 1'b1;
    rsaddr = 5'd12; #1;
    chk("final_r12", rsdata, 32'd0);
    chk("final_overrun", {31'd0, overrun}, 32'd0);
    chk("final_retired", retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
